// File: rtl/frame_scanout_if.sv
// Purpose : frame buffer read port, video outputs and the renderer swap handshake of frame_scanout.
// Ports   : master = scanout side (drives read_addr_out, video and swap status),
//           slave  = surroundings (drive read_data_in and swap_req).
interface frame_scanout_if #(
   parameter int BUFFER_ADDR_WIDTH = 15,
   parameter int COLOR_WIDTH       = 12
);
   logic [BUFFER_ADDR_WIDTH:0] read_addr_out;   // MSB selects the front buffer
   logic [COLOR_WIDTH-1:0]     read_data_in;    // valid one clock after the address
   logic                       hsync;           // active low
   logic                       vsync;           // active low
   logic                       de;              // active video
   logic [COLOR_WIDTH-1:0]     color_out;       // zero outside active video
   logic                       swap_req;        // renderer: back buffer complete
   logic                       swap_ack;        // one-clock pulse when the swap happens
   logic                       front_sel;       // buffer on screen
   logic                       vblank_start;    // one-clock pulse at the first vblank line

   modport master (
      output read_addr_out, hsync, vsync, de, color_out, swap_ack, front_sel, vblank_start,
      input  read_data_in, swap_req
   );

   modport slave (
      input  read_addr_out, hsync, vsync, de, color_out, swap_ack, front_sel, vblank_start,
      output read_data_in, swap_req
   );
endinterface

// File: rtl/frame_scanout.sv
// Purpose : VGA scanout of a double-buffered frame buffer, each stored pixel shown SCALE x SCALE;
//           owns front/back selection and swaps only at vblank start on renderer request.
// Latency : fixed 2 clocks from counter state to hsync/vsync/de/color_out; no backpressure,
//           the pixel clock free-runs and swap requests wait for the next vblank.
// Ports   : clk, rstn (async active low), bus (frame_scanout_if.master).
module frame_scanout #(
   parameter int BUFFER_WIDTH      = 160,
   parameter int BUFFER_HEIGHT     = 120,
   parameter int BUFFER_ADDR_WIDTH = $clog2(BUFFER_WIDTH*BUFFER_HEIGHT),
   parameter int SCALE             = 4,
   parameter int COLOR_WIDTH       = 12,
   parameter int H_ACTIVE          = 640,
   parameter int H_FP              = 16,
   parameter int H_SYNC            = 96,
   parameter int H_BP              = 48,
   parameter int V_ACTIVE          = 480,
   parameter int V_FP              = 10,
   parameter int V_SYNC            = 2,
   parameter int V_BP              = 33
) (
   input  logic            clk,
   input  logic            rstn,
   frame_scanout_if.master bus
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HW      = $clog2(H_TOTAL);
   localparam int VW      = $clog2(V_TOTAL);
   localparam int XW      = (BUFFER_WIDTH > 1) ? $clog2(BUFFER_WIDTH) : 1;
   localparam int SW      = (SCALE > 1) ? $clog2(SCALE) : 1;
   localparam int AW      = BUFFER_ADDR_WIDTH;

   localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
   localparam logic [HW-1:0] H_ACT      = HW'(H_ACTIVE);
   localparam logic [HW-1:0] H_ACT_LAST = HW'(H_ACTIVE - 1);
   localparam logic [HW-1:0] HS_FIRST   = HW'(H_ACTIVE + H_FP);
   localparam logic [HW-1:0] HS_LAST    = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
   localparam logic [VW-1:0] V_ACT      = VW'(V_ACTIVE);
   localparam logic [VW-1:0] V_ACT_LAST = VW'(V_ACTIVE - 1);
   localparam logic [VW-1:0] VS_FIRST   = VW'(V_ACTIVE + V_FP);
   localparam logic [VW-1:0] VS_LAST    = VW'(V_ACTIVE + V_FP + V_SYNC - 1);
   localparam logic [SW-1:0] SUB_LAST   = SW'(SCALE - 1);
   localparam logic [AW-1:0] ROW_STEP   = AW'(BUFFER_WIDTH);

   typedef enum logic {S_IDLE, S_PENDING} state_t;

   // Raster position and the replicated frame buffer coordinates that track it.
   logic [HW-1:0]      r_h_cnt;
   logic [VW-1:0]      r_v_cnt;
   logic [SW-1:0]      r_x_sub;
   logic [XW-1:0]      r_x_idx;
   logic [SW-1:0]      r_y_sub;
   logic [AW-1:0]      r_row_base;
   logic [AW:0]        r_addr;
   logic               r_vblank;

   // Two-stage alignment of the timing signals with the frame buffer read.
   logic               r_de_d1, r_hs_d1, r_vs_d1;
   logic               r_de, r_hs, r_vs;
   logic [COLOR_WIDTH-1:0] r_color;

   state_t             r_state;
   logic               r_front_sel;
   logic               r_armed;

   logic               w_h_end, w_v_end;
   logic [HW-1:0]      w_h_nxt;
   logic [VW-1:0]      w_v_nxt;
   logic [SW-1:0]      w_x_sub_nxt, w_y_sub_nxt;
   logic [XW-1:0]      w_x_idx_nxt;
   logic [AW-1:0]      w_row_nxt;
   logic               w_act, w_act_nxt, w_vbl_nxt, w_hs, w_vs;
   logic               w_req_ok, w_swap;

   always_comb begin
      w_h_end     = (r_h_cnt == H_LAST);
      w_v_end     = (r_v_cnt == V_LAST);
      w_h_nxt     = w_h_end ? '0 : r_h_cnt + 1'b1;
      w_v_nxt     = r_v_cnt;
      if (w_h_end) begin
         w_v_nxt = w_v_end ? '0 : r_v_cnt + 1'b1;
      end

      // Column replication: stops on the last active pixel, restarts with the line.
      w_x_sub_nxt = r_x_sub;
      w_x_idx_nxt = r_x_idx;
      if (w_h_end) begin
         w_x_sub_nxt = '0;
         w_x_idx_nxt = '0;
      end else if (r_h_cnt < H_ACT_LAST) begin
         if (r_x_sub == SUB_LAST) begin
            w_x_sub_nxt = '0;
            w_x_idx_nxt = r_x_idx + 1'b1;
         end else begin
            w_x_sub_nxt = r_x_sub + 1'b1;
         end
      end

      // Line replication: row_base steps a whole buffer line every SCALE active lines,
      // which keeps the address an adder rather than a multiplier.
      w_y_sub_nxt = r_y_sub;
      w_row_nxt   = r_row_base;
      if (w_h_end) begin
         if (w_v_end) begin
            w_y_sub_nxt = '0;
            w_row_nxt   = '0;
         end else if (r_v_cnt < V_ACT_LAST) begin
            if (r_y_sub == SUB_LAST) begin
               w_y_sub_nxt = '0;
               w_row_nxt   = r_row_base + ROW_STEP;
            end else begin
               w_y_sub_nxt = r_y_sub + 1'b1;
            end
         end
      end

      w_act_nxt = (w_h_nxt < H_ACT) && (w_v_nxt < V_ACT);
      w_vbl_nxt = (w_h_nxt == '0) && (w_v_nxt == V_ACT);
      w_act     = (r_h_cnt < H_ACT) && (r_v_cnt < V_ACT);
      w_hs      = ~((r_h_cnt >= HS_FIRST) && (r_h_cnt <= HS_LAST));
      w_vs      = ~((r_v_cnt >= VS_FIRST) && (r_v_cnt <= VS_LAST));
   end

   // Address and vblank pulse are loaded from next-state values so that they line up
   // with the counter state of the same cycle; the address holds outside active video.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_h_cnt    <= '0;
         r_v_cnt    <= '0;
         r_x_sub    <= '0;
         r_x_idx    <= '0;
         r_y_sub    <= '0;
         r_row_base <= '0;
         r_addr     <= '0;
         r_vblank   <= 1'b0;
      end else begin
         r_h_cnt    <= w_h_nxt;
         r_v_cnt    <= w_v_nxt;
         r_x_sub    <= w_x_sub_nxt;
         r_x_idx    <= w_x_idx_nxt;
         r_y_sub    <= w_y_sub_nxt;
         r_row_base <= w_row_nxt;
         r_vblank   <= w_vbl_nxt;
         if (w_act_nxt) begin
            r_addr <= {r_front_sel, w_row_nxt + AW'(w_x_idx_nxt)};
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_de_d1 <= 1'b0;
         r_hs_d1 <= 1'b1;
         r_vs_d1 <= 1'b1;
         r_de    <= 1'b0;
         r_hs    <= 1'b1;
         r_vs    <= 1'b1;
         r_color <= '0;
      end else begin
         r_de_d1 <= w_act;
         r_hs_d1 <= w_hs;
         r_vs_d1 <= w_vs;
         r_de    <= r_de_d1;
         r_hs    <= r_hs_d1;
         r_vs    <= r_vs_d1;
         r_color <= r_de_d1 ? bus.read_data_in : '0;
      end
   end

   // A request only counts once swap_req has been seen low since the last swap, so a
   // level request cannot swap again every frame. swap_ack is decoded from registered
   // state plus swap_req so a request arriving in the vblank_start cycle itself is served
   // in that cycle.
   assign w_req_ok = bus.swap_req & r_armed;
   assign w_swap   = r_vblank & ((r_state == S_PENDING) | w_req_ok);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state     <= S_IDLE;
         r_front_sel <= 1'b0;
         r_armed     <= 1'b1;
      end else if (w_swap) begin
         r_state     <= S_IDLE;
         r_front_sel <= ~r_front_sel;
         r_armed     <= 1'b0;
      end else begin
         if ((r_state == S_IDLE) && w_req_ok) begin
            r_state <= S_PENDING;
         end
         if (!bus.swap_req) begin
            r_armed <= 1'b1;
         end
      end
   end

   assign bus.read_addr_out = r_addr;
   assign bus.hsync         = r_hs;
   assign bus.vsync         = r_vs;
   assign bus.de            = r_de;
   assign bus.color_out     = r_color;
   assign bus.swap_ack      = w_swap;
   assign bus.front_sel     = r_front_sel;
   assign bus.vblank_start  = r_vblank;

endmodule

// File: tb/tb_frame_scanout.sv
// Purpose : directed bench for frame_scanout on a reduced raster (8x6 buffer, x4 replication).
// Latency : compares every output each cycle against a raster model derived from the cycle
//           count since reset release; the frame buffer is a 1-clock read model.
// Ports   : none (top level); drives swap_req and read_data_in through frame_scanout_if.
module tb_frame_scanout;

   localparam int BW  = 8;
   localparam int BH  = 6;
   localparam int S   = 4;
   localparam int BAW = $clog2(BW*BH);
   localparam int CW  = 12;
   localparam int HA  = 32, HFP = 4, HSY = 6, HBP = 6;
   localparam int VA  = 24, VFP = 2, VSY = 2, VBP = 3;
   localparam int HT  = HA + HFP + HSY + HBP;   // 48
   localparam int VT  = VA + VFP + VSY + VBP;   // 31
   localparam int FRAME = HT * VT;              // 1488
   localparam int VBL   = VA * HT;              // 1152: vblank_start offset in a frame

   logic clk;
   logic rstn;

   frame_scanout_if #(.BUFFER_ADDR_WIDTH(BAW), .COLOR_WIDTH(CW)) bus ();

   frame_scanout #(
      .BUFFER_WIDTH(BW), .BUFFER_HEIGHT(BH), .BUFFER_ADDR_WIDTH(BAW), .SCALE(S),
      .COLOR_WIDTH(CW),
      .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
      .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP)
   ) dut (
      .clk(clk),
      .rstn(rstn),
      .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [CW-1:0] memf(input logic [BAW:0] a);
      int t;
      t = int'(a) * 97 + 13;
      return t[CW-1:0];
   endfunction

   // Frame buffer model: registered read, data one clock after the address.
   always @(posedge clk) bus.read_data_in <= memf(bus.read_addr_out);

   int n_tests = 0;
   int n_fail  = 0;
   int cyc;
   logic exp_fs;
   logic [BAW:0] exp_addr, a1, a2;
   int exp_acks [$];
   int e_addr, e_de, e_hs, e_vs, e_col, e_vbl, e_ack, e_fs;
   int c_de, c_hs, c_vs;
   bit spot_en;
   int spot_cyc [10] = '{0, 3, 4, 31, 52, 175, 192, 1135, 1136, 1200};
   int spot_exp [10] = '{0, 0, 1,  7,  1,   7,   8,   47,   47,   47};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic rst_chk(input string p);
      chk({p, "_hsync"},     32'(bus.hsync),         1);
      chk({p, "_vsync"},     32'(bus.vsync),         0 + 1);
      chk({p, "_de"},        32'(bus.de),            0);
      chk({p, "_color"},     32'(bus.color_out),     0);
      chk({p, "_addr"},      32'(bus.read_addr_out), 0);
      chk({p, "_front_sel"}, 32'(bus.front_sel),     0);
      chk({p, "_swap_ack"},  32'(bus.swap_ack),      0);
      chk({p, "_vblank"},    32'(bus.vblank_start),  0);
   endtask

   task automatic model_reset();
      cyc      = 0;
      exp_fs   = 1'b0;
      exp_addr = '0;
      a1       = '0;
      a2       = '0;
      exp_acks.delete();
   endtask

   // Check the current cycle against the raster model, then advance one clock.
   task automatic tick();
      int h, v, hd, vd;
      logic de_x, hs_x, vs_x, ack_x, vbl_x;
      logic [CW-1:0] col_x;
      h = cyc % HT;
      v = (cyc / HT) % VT;
      if (h < HA && v < VA) exp_addr = {exp_fs, BAW'((v / S) * BW + h / S)};
      if (cyc >= 2) begin
         hd   = (cyc - 2) % HT;
         vd   = ((cyc - 2) / HT) % VT;
         de_x = (hd < HA) && (vd < VA);
         hs_x = !((hd >= HA + HFP) && (hd <= HA + HFP + HSY - 1));
         vs_x = !((vd >= VA + VFP) && (vd <= VA + VFP + VSY - 1));
      end else begin
         de_x = 1'b0;
         hs_x = 1'b1;
         vs_x = 1'b1;
      end
      col_x = de_x ? memf(a2) : '0;
      vbl_x = (h == 0) && (v == VA);
      ack_x = 1'b0;
      if (exp_acks.size() > 0) ack_x = (exp_acks[0] == cyc);

      if (bus.read_addr_out !== exp_addr) e_addr++;
      if (bus.de            !== de_x)     e_de++;
      if (bus.hsync         !== hs_x)     e_hs++;
      if (bus.vsync         !== vs_x)     e_vs++;
      if (bus.color_out     !== col_x)    e_col++;
      if (bus.vblank_start  !== vbl_x)    e_vbl++;
      if (bus.swap_ack      !== ack_x)    e_ack++;
      if (bus.front_sel     !== exp_fs)   e_fs++;
      if (bus.de === 1'b1)    c_de++;
      if (bus.hsync === 1'b0) c_hs++;
      if (bus.vsync === 1'b0) c_vs++;

      if (spot_en) begin
         for (int i = 0; i < 10; i++) begin
            if (cyc == spot_cyc[i]) chk($sformatf("addr_c%0d", cyc), 32'(bus.read_addr_out), spot_exp[i]);
         end
      end

      a2 = a1;
      a1 = exp_addr;
      if (ack_x) begin
         void'(exp_acks.pop_front());
         exp_fs = ~exp_fs;
      end
      @(negedge clk);
      #1;
      cyc++;
   endtask

   task automatic report(input string ph);
      chk({ph, "_addr_errs"},  e_addr, 0);
      chk({ph, "_de_errs"},    e_de,   0);
      chk({ph, "_hsync_errs"}, e_hs,   0);
      chk({ph, "_vsync_errs"}, e_vs,   0);
      chk({ph, "_color_errs"}, e_col,  0);
      chk({ph, "_vblank_errs"},e_vbl,  0);
      chk({ph, "_ack_errs"},   e_ack,  0);
      chk({ph, "_fsel_errs"},  e_fs,   0);
      e_addr = 0; e_de = 0; e_hs = 0; e_vs = 0;
      e_col  = 0; e_vbl = 0; e_ack = 0; e_fs = 0;
   endtask

   initial begin
      bus.swap_req = 1'b0;
      rstn         = 1'b0;
      e_addr = 0; e_de = 0; e_hs = 0; e_vs = 0;
      e_col  = 0; e_vbl = 0; e_ack = 0; e_fs = 0;
      c_de   = 0; c_hs = 0; c_vs = 0;
      spot_en = 1'b1;
      model_reset();
      repeat (3) @(negedge clk);
      #1;
      rst_chk("reset");

      // Frame 0: release, 2-clock pipeline fill, full raster and address pattern.
      rstn = 1'b1;
      chk("de_after_release_c0", 32'(bus.de), 0);
      tick();
      chk("de_after_release_c1", 32'(bus.de), 0);
      tick();
      chk("de_after_release_c2", 32'(bus.de), 1);
      while (cyc < FRAME) tick();
      spot_en = 1'b0;
      report("frame0");
      chk("de_cycles_per_frame",   c_de, HA * VA);
      chk("hsync_low_per_frame",   c_hs, HSY * VT);
      chk("vsync_low_per_frame",   c_vs, VSY * HT);

      // Frame 1: one-clock request mid-frame, swap waits for vblank_start.
      while (cyc < FRAME + 5 * HT + 10) tick();
      exp_acks.push_back(FRAME + VBL);
      bus.swap_req = 1'b1;
      tick();
      bus.swap_req = 1'b0;
      while (cyc < 2 * FRAME) tick();
      report("swap_pulse");
      chk("addr_msb_after_swap", 32'(bus.read_addr_out), 64);
      chk("front_sel_after_swap", 32'(bus.front_sel), 1);

      // Frame 2: request first raised inside the vblank_start cycle.
      while (cyc < 2 * FRAME + VBL) tick();
      exp_acks.push_back(2 * FRAME + VBL);
      bus.swap_req = 1'b1;
      #1;
      chk("ack_same_cycle", 32'(bus.swap_ack), 1);
      tick();
      bus.swap_req = 1'b0;
      while (cyc < 3 * FRAME) tick();
      report("swap_same_cycle");
      chk("front_sel_back_to_0", 32'(bus.front_sel), 0);

      // Frames 3-5: level request held three frames swaps once.
      while (cyc < 3 * FRAME + 100) tick();
      exp_acks.push_back(3 * FRAME + VBL);
      bus.swap_req = 1'b1;
      while (cyc < 6 * FRAME) tick();
      bus.swap_req = 1'b0;
      report("swap_level");
      chk("front_sel_after_level", 32'(bus.front_sel), 1);

      // Frame 6: reset mid-frame at line 10, pixel 20, then restart from the origin.
      while (cyc < 6 * FRAME + 10 * HT + 20) tick();
      rstn = 1'b0;
      #1;
      rst_chk("midreset");
      repeat (2) @(negedge clk);
      #1;
      rstn = 1'b1;
      model_reset();
      chk("restart_addr", 32'(bus.read_addr_out), 0);
      chk("restart_front_sel", 32'(bus.front_sel), 0);
      while (cyc < FRAME) tick();
      report("after_reset");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
